mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, is the count register and limit width.
REQ-002 Parameter STEP_W, default 4, is the step input width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 srst  input  1  reset, synchronous and active-high.
REQ-005 ena  input  1  count enable.
REQ-006 sel  input  1  direction: 0 up, 1 down.
REQ-007 sload  input  1  synchronous load strobe.
REQ-008 d_load  input  WIDTH  load value.
REQ-009 step  input  STEP_W  increment/decrement magnitude.
REQ-010 top  input  WIDTH  inclusive upper limit; the count range is 0..top.
REQ-011 sat  input  1  limit mode: 0 wrap (modulo top+1), 1 saturate.
REQ-012 cmp  input  WIDTH  compare value.
REQ-013 ovf_clr  input  1  clears the sticky overflow flag.
REQ-014 q  output  WIDTH  registered count.
REQ-015 carry_out  output  1  registered one-cycle limit-event pulse.
REQ-016 match  output  1  registered one-cycle compare pulse.
REQ-017 ovf  output  1  sticky overflow flag.

Function
REQ-018 Per-cycle priority SHALL be srst > sload > (ena count) > hold; sload SHALL act regardless of ena.
REQ-019 The load SHALL set q = min(d_load, top) and SHALL force carry_out=0 and match=0 for that cycle.
REQ-020 The count arithmetic SHALL use eq = min(q, top) and es = min(zero-extended step, top+1), evaluated in WIDTH+1 bits so that top = all-ones is legal.
REQ-021 When es = 0 and ena = 1, q SHALL hold and no event SHALL be raised.
REQ-022 For an up count, s = eq + es; if s <= top then q = s with no limit event; if s > top, wrap mode SHALL give q = s - (top+1) and saturate mode SHALL give q = top.
REQ-023 For a down count, if eq >= es then q = eq - es with no limit event; if eq < es, wrap mode SHALL give q = eq + (top+1) - es and saturate mode SHALL give q = 0.
REQ-024 A limit event is either branch of REQ-022/023 with s > top or eq < es; carry_out SHALL be 1 in the cycle after the event edge, including repeated clamps while already at the limit in saturate mode.
REQ-025 match SHALL be 1 in the cycle after a count update (not load, not hold) whose new q equals cmp.
REQ-026 A limit event SHALL set ovf; ovf_clr SHALL clear ovf; when both occur in the same cycle, the set SHALL win.
REQ-027 A change of top while q > top SHALL NOT alter q until the next load or count update.
REQ-028 With ena = 0 and sload = 0, carry_out and match SHALL be 0 and q SHALL hold.
REQ-029 Latency SHALL be one clock from input sample to q, carry_out, match and ovf; there SHALL be no combinational input-to-output path.

Reset
REQ-030 srst SHALL set q = 0, carry_out = 0, match = 0 and ovf = 0 on the next edge, overriding sload, ena and ovf_clr.
REQ-031 srst asserted mid-count SHALL discard the pending update and raise no event.
REQ-032 After srst deasserts, the first enabled count SHALL proceed from q = 0.

Verification
REQ-033 Wrap up: WIDTH=8, top=9, step=3, sat=0, sel=0, ena=1 from q=0 -> q = 3, 6, 9, 2; carry_out=1 only with q=2; ovf=1 from then on.
REQ-034 Saturate down: top=9, load 5, step=4, sel=1, sat=1 -> q = 1, 0, 0; carry_out=1 on both cycles with q=0; cmp=1 -> match=1 only with the first q=1.
REQ-035 Clip: top=99, sload=1, d_load=200 -> q=99 and carry_out=0; then top=255, step=1, up wrap from load 255 -> q=0 with carry_out=1.
REQ-036 Step bounds: step=0, ena=1 -> q holds, carry_out=match=0; top=3, step=15, up wrap from 2 -> es=4, q=2 and carry_out=1.
REQ-037 Flag race: a limit event with ovf_clr=1 in the same cycle -> ovf=1; ovf_clr alone next cycle -> ovf=0.
REQ-038 Reset: srst=1 together with sload=1, d_load=7 while counting -> q=0 and all flags 0; first count after release gives q = es.

Source files
------------

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap or saturate limit handling, load clip,
// compare pulse and sticky overflow flag. All outputs are registered.
module mod_counter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              ena,
   input  logic              sel,
   input  logic              sload,
   input  logic [WIDTH-1:0]  d_load,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  top,
   input  logic              sat,
   input  logic [WIDTH-1:0]  cmp,
   input  logic              ovf_clr,
   output logic [WIDTH-1:0]  q,
   output logic              carry_out,
   output logic              match,
   output logic              ovf
);

   localparam int unsigned W1 = WIDTH + 1;
   localparam int unsigned CW = (STEP_W > W1) ? STEP_W : W1;

   logic [WIDTH-1:0] q_q, q_d;
   logic             carry_q, carry_d;
   logic             match_q, match_d;
   logic             ovf_q, ovf_d;

   logic [W1-1:0]    top_x;
   logic [W1-1:0]    topp1;
   logic [W1-1:0]    eq_x;
   logic [W1-1:0]    es;
   logic [CW-1:0]    step_c;
   logic [CW-1:0]    lim_c;
   logic [W1-1:0]    up_sum;
   logic [W1-1:0]    dn_wrap;
   logic [W1-1:0]    nxt;
   logic             limit;

   // Operands widened by one bit so top = all-ones needs no special case.
   always_comb begin
      top_x   = {1'b0, top};
      topp1   = top_x + W1'(1);
      eq_x    = (q_q > top) ? top_x : {1'b0, q_q};
      step_c  = CW'(step);
      lim_c   = CW'(topp1);
      es      = (step_c < lim_c) ? W1'(step_c) : topp1;
      up_sum  = eq_x + es;
      dn_wrap = eq_x + topp1 - es;
   end

   // Next-state: load, count, or hold.
   always_comb begin
      q_d     = q_q;
      carry_d = 1'b0;
      match_d = 1'b0;
      ovf_d   = ovf_q & ~ovf_clr;
      nxt     = {1'b0, q_q};
      limit   = 1'b0;

      if (sload) begin
         q_d = (d_load > top) ? top : d_load;
      end else if (ena && (es != '0)) begin
         if (!sel) begin
            if (up_sum > top_x) begin
               limit = 1'b1;
               nxt   = sat ? top_x : (up_sum - topp1);
            end else begin
               nxt   = up_sum;
            end
         end else begin
            if (eq_x < es) begin
               limit = 1'b1;
               nxt   = sat ? '0 : dn_wrap;
            end else begin
               nxt   = eq_x - es;
            end
         end
         q_d     = WIDTH'(nxt);
         carry_d = limit;
         match_d = (WIDTH'(nxt) == cmp);
         ovf_d   = limit | (ovf_q & ~ovf_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         q_q     <= '0;
         carry_q <= 1'b0;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         q_q     <= q_d;
         carry_q <= carry_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q         = q_q;
   assign carry_out = carry_q;
   assign match     = match_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter with hand-computed expected values.
module tb_mod_counter;

   logic       clk = 1'b0;
   logic       srst, ena, sel, sload, sat, ovf_clr;
   logic [7:0] d_load, top, cmp;
   logic [3:0] step;
   logic [7:0] q;
   logic       carry_out, match, ovf;

   int n_cmp = 0;
   int n_bad = 0;

   mod_counter #(.WIDTH(8), .STEP_W(4)) dut (
      .clk(clk), .srst(srst), .ena(ena), .sel(sel), .sload(sload),
      .d_load(d_load), .step(step), .top(top), .sat(sat), .cmp(cmp),
      .ovf_clr(ovf_clr), .q(q), .carry_out(carry_out), .match(match),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk4(input string tag, input int eq, input int ec, input int em, input int eo);
      check({tag, ".q"}, 32'(q), 32'(eq));
      check({tag, ".carry"}, 32'(carry_out), 32'(ec));
      check({tag, ".match"}, 32'(match), 32'(em));
      check({tag, ".ovf"}, 32'(ovf), 32'(eo));
   endtask

   initial begin
      srst = 1'b1; ena = 1'b0; sel = 1'b0; sload = 1'b0; sat = 1'b0;
      ovf_clr = 1'b0; d_load = 8'd0; top = 8'd9; cmp = 8'd6; step = 4'd3;
      tick();
      chk4("reset", 0, 0, 0, 0);

      // Wrap up: 3, 6, 9, 2, 5
      srst = 1'b0; ena = 1'b1;
      tick(); chk4("wrap_up1", 3, 0, 0, 0);
      tick(); chk4("wrap_up2", 6, 0, 1, 0);
      tick(); chk4("wrap_up3", 9, 0, 0, 0);
      tick(); chk4("wrap_up4", 2, 1, 0, 1);
      tick(); chk4("wrap_up5", 5, 0, 0, 1);

      // Hold with ovf_clr
      ena = 1'b0; ovf_clr = 1'b1;
      tick(); chk4("hold_clr", 5, 0, 0, 0);
      ovf_clr = 1'b0;

      // Saturate down from 5, step 4
      sload = 1'b1; d_load = 8'd5; cmp = 8'd1;
      tick(); chk4("load5", 5, 0, 0, 0);
      sload = 1'b0; ena = 1'b1; sel = 1'b1; sat = 1'b1; step = 4'd4;
      tick(); chk4("sat_dn1", 1, 0, 1, 0);
      tick(); chk4("sat_dn2", 0, 1, 0, 1);
      tick(); chk4("sat_dn3", 0, 1, 0, 1);

      // Flag race: clamp again with ovf_clr, then clear alone
      ovf_clr = 1'b1;
      tick(); chk4("race_set", 0, 1, 0, 1);
      ena = 1'b0;
      tick(); chk4("race_clr", 0, 0, 0, 0);
      ovf_clr = 1'b0;

      // Load clip, then full-range wrap
      ena = 1'b1; sload = 1'b1; top = 8'd99; d_load = 8'd200; cmp = 8'd50;
      tick(); chk4("clip", 99, 0, 0, 0);
      top = 8'd255; d_load = 8'd255;
      tick(); chk4("load255", 255, 0, 0, 0);
      sload = 1'b0; sel = 1'b0; sat = 1'b0; step = 4'd1;
      tick(); chk4("full_wrap", 0, 1, 0, 1);

      // Zero step holds, no match even though q == cmp
      step = 4'd0; cmp = 8'd0;
      tick(); chk4("step0", 0, 0, 0, 1);

      // Oversized step clipped to top+1
      top = 8'd3; sload = 1'b1; d_load = 8'd2;
      tick(); chk4("load2", 2, 0, 0, 1);
      sload = 1'b0; step = 4'd15; cmp = 8'd2;
      tick(); chk4("step_clip", 2, 1, 1, 1);

      // Down wrap: top 9, from 1 by 3 -> 8
      top = 8'd9; sload = 1'b1; d_load = 8'd1;
      tick(); chk4("load1", 1, 0, 0, 1);
      sload = 1'b0; sel = 1'b1; step = 4'd3;
      tick(); chk4("dn_wrap", 8, 1, 0, 1);

      // Lowering top below q does not move q until a count update
      ena = 1'b0; top = 8'd5;
      tick(); chk4("top_shrink", 8, 0, 0, 1);
      ena = 1'b1; sel = 1'b0; step = 4'd1; cmp = 8'd0;
      tick(); chk4("shrunk_wrap", 0, 1, 1, 1);

      // Reset mid-count overrides load
      top = 8'd9; step = 4'd3; cmp = 8'd200;
      tick(); chk4("pre_rst", 3, 0, 0, 1);
      srst = 1'b1; sload = 1'b1; d_load = 8'd7;
      tick(); chk4("rst_mid", 0, 0, 0, 0);
      srst = 1'b0; sload = 1'b0;
      tick(); chk4("post_rst", 3, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
